// File: rtl/logic_serial_ctrl.sv
// Bit-serial controller feeding an external 1-bit logic slice.
// Streams operands LSB first and collects the slice output into result.
module logic_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_opsel0,
  output logic             slice_opsel1,
  output logic             slice_opsel2,
  input  logic             slice_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_prev;
  logic [WIDTH-1:0] r_result;
  logic             r_err;
  logic             r_zero;

  logic             w_run;
  logic             w_accept;
  logic             w_legal;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_run     = (r_state == RUN);
  assign w_accept  = (r_state == IDLE) && start;
  assign w_legal   = ~op[2] | (op[1:0] == 2'b00);
  assign w_last    = w_run && (r_cnt == CW'(WIDTH - 1));
  assign w_res_nxt = {slice_out, r_result[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = w_legal ? RUN : DONE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_prev   <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_err  <= ~w_legal;
      r_zero <= ~w_legal;
      if (w_legal) begin
        r_a    <= a_in;
        r_b    <= b_in;
        r_op   <= op;
        r_cnt  <= '0;
        r_prev <= 1'b0;
      end else begin
        r_result <= '0;
      end
    end else if (w_run) begin
      // prev holds A[k-1] so the slice can implement shift-left via cin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_prev   <= r_a[0];
      r_result <= w_res_nxt;
      if (w_last) begin
        r_zero <= (w_res_nxt == '0);
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign busy         = w_run;
  assign done         = (r_state == DONE);
  assign err          = r_err;
  assign zero         = r_zero;
  assign result       = r_result;
  assign slice_a      = w_run & r_a[0];
  assign slice_b      = w_run & r_b[0];
  assign slice_cin    = w_run & r_prev;
  assign slice_opsel0 = w_run & r_op[0];
  assign slice_opsel1 = w_run & r_op[1];
  assign slice_opsel2 = w_run & r_op[2];

endmodule
